frame_slot_manager: RTL and testbench

Parametrised frame-buffer slot manager for the video denoise pipeline. It owns NUM_SLOTS fixed frame regions in external memory and hands them, in frame order, through NUM_STAGES consumers: stage 0 is the stream-to-memory writer, stage 1 is the noise-estimation reader, and stage 2 is the Wiener reader. This replaces the single base-address hand-off chain with a multi-frame ring, so the writer can run ahead of the readers. Each stage receives a registered base address per granted frame and returns the slot with a done pulse.

---
 rtl/frame_slot_pkg.sv | 16 +
 rtl/frame_slot_manager_slot_fifo.sv | 63 ++++++
 rtl/frame_slot_manager.sv | 129 ++++++++++++
 tb/tb_frame_slot_manager.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/frame_slot_pkg.sv
// Shared types and helpers for the frame-buffer slot manager.
package frame_slot_pkg;

  localparam int unsigned MAX_SLOT_W = 16;
  localparam int unsigned DROP_CNT_W = 16;

  typedef logic [MAX_SLOT_W-1:0] slot_idx_t;

  // Base address of a slot; callers truncate to their address width.
  function automatic logic [63:0] slot_addr(input logic [63:0] base,
                                            input slot_idx_t   idx,
                                            input logic [63:0] stride);
    return base + 64'(idx) * stride;
  endfunction

endpackage

// File: rtl/frame_slot_manager_slot_fifo.sv
// Circular FIFO of slot indices, depth NUM_SLOTS, optionally preloaded
// with 0..NUM_SLOTS-1 on reset (used for the free list).
module slot_fifo #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter bit          INIT_FULL = 1'b0,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [SLOT_W-1:0] wr_data,
  input  logic              pop,
  output logic [SLOT_W-1:0] rd_data_c,
  output logic [SLOT_W:0]   count,
  output logic              empty,
  output logic              full
);

  logic [SLOT_W-1:0] mem [NUM_SLOTS];
  logic [SLOT_W-1:0] rd_ptr;
  logic [SLOT_W-1:0] wr_ptr;
  logic [SLOT_W:0]   count_nxt;

  assign rd_data_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count + (SLOT_W+1)'(push) - (SLOT_W+1)'(pop);
  end

  // Pointers wrap naturally because NUM_SLOTS is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      if (INIT_FULL) begin
        count <= (SLOT_W+1)'(NUM_SLOTS);
        empty <= 1'b0;
        full  <= 1'b1;
      end else begin
        count <= '0;
        empty <= 1'b1;
        full  <= 1'b0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + SLOT_W'(1);
      if (pop)  rd_ptr <= rd_ptr + SLOT_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == (SLOT_W+1)'(NUM_SLOTS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_FULL) begin
        for (int i = 0; i < int'(NUM_SLOTS); i++) mem[i] <= SLOT_W'(i);
      end
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/frame_slot_manager.sv
// Multi-frame slot ring for the denoise pipeline: slots flow in frame order
// writer -> noise estimator -> Wiener reader -> free list.
// Optional feature: FRAME_SLOT_DROP_EN lets the writer reclaim the oldest
// unclaimed written frame when the free list is empty.
module frame_slot_manager import frame_slot_pkg::*; #(
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned NUM_SLOTS           = 4,
  parameter int unsigned NUM_STAGES          = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0] SLOT_STRIDE = ADDR_WIDTH'(32'h0010_0000),
  localparam int unsigned SLOT_W             = $clog2(NUM_SLOTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_STAGES-1:0]            stage_req,
  input  logic [NUM_STAGES-1:0]            stage_done,
  output logic [NUM_STAGES-1:0]            stage_grant,
  output logic [NUM_STAGES*ADDR_WIDTH-1:0] stage_base_addr,
  output logic [NUM_STAGES-1:0]            stage_busy,
  output logic [SLOT_W:0]                  free_slots,
  output logic [DROP_CNT_W-1:0]            drop_count,
  output logic                             protocol_err
);

  logic [NUM_STAGES-1:0] q_push;
  logic [NUM_STAGES-1:0] q_pop;
  logic [NUM_STAGES-1:0] q_empty;
  logic [NUM_STAGES-1:0] q_full;
  logic [SLOT_W-1:0]     q_wr_data [NUM_STAGES];
  logic [SLOT_W-1:0]     q_rd_data [NUM_STAGES];
  logic [SLOT_W:0]       q_count   [NUM_STAGES];

  logic [SLOT_W-1:0]     held_q     [NUM_STAGES];
  logic [SLOT_W-1:0]     gnt_slot_c [NUM_STAGES];
  logic [NUM_STAGES-1:0] grant_c;
  logic [NUM_STAGES-1:0] done_ok_c;
  logic                  err_c;
  logic                  drop_c;
  int unsigned           slot_total_c;

  // q[0] is the free list and starts holding every slot.
  for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_q
    slot_fifo #(
      .NUM_SLOTS (NUM_SLOTS),
      .INIT_FULL (k == 0)
    ) u_q (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push[k]),
      .wr_data   (q_wr_data[k]),
      .pop       (q_pop[k]),
      .rd_data_c (q_rd_data[k]),
      .count     (q_count[k]),
      .empty     (q_empty[k]),
      .full      (q_full[k])
    );
  end

  assign free_slots = q_count[0];

  // Per-stage grant/done decode; a done from stage k feeds the next stage's queue.
  always_comb begin
    q_push    = '0;
    q_pop     = '0;
    grant_c   = '0;
    done_ok_c = '0;
    err_c     = 1'b0;
    drop_c    = 1'b0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      q_wr_data[k]  = '0;
      gnt_slot_c[k] = q_rd_data[k];
    end
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      done_ok_c[k] = stage_done[k] & stage_busy[k];
      if (stage_done[k] && !stage_busy[k]) err_c = 1'b1;
      grant_c[k] = stage_req[k] & ~stage_busy[k] & ~q_empty[k];
      q_pop[k]   = grant_c[k];
    end
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      q_push[(k + 1) % int'(NUM_STAGES)]    = done_ok_c[k];
      q_wr_data[(k + 1) % int'(NUM_STAGES)] = held_q[k];
    end
`ifdef FRAME_SLOT_DROP_EN
    // Writer steals the oldest written-but-unclaimed frame; it beats stage 1 for q[1].
    if (stage_req[0] && !stage_busy[0] && q_empty[0] && !q_empty[1]) begin
      drop_c        = 1'b1;
      grant_c[0]    = 1'b1;
      gnt_slot_c[0] = q_rd_data[1];
      grant_c[1]    = 1'b0;
      q_pop[1]      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_grant     <= '0;
      stage_busy      <= '0;
      stage_base_addr <= '0;
      drop_count      <= '0;
      protocol_err    <= 1'b0;
      for (int k = 0; k < int'(NUM_STAGES); k++) held_q[k] <= '0;
    end else begin
      stage_grant <= grant_c;
      stage_busy  <= (stage_busy & ~done_ok_c) | grant_c;
      if (err_c) protocol_err <= 1'b1;
      if (drop_c && drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        if (grant_c[k]) begin
          held_q[k] <= gnt_slot_c[k];
          stage_base_addr[k*ADDR_WIDTH +: ADDR_WIDTH] <=
            ADDR_WIDTH'(slot_addr(64'(BASE_ADDR), slot_idx_t'(gnt_slot_c[k]), 64'(SLOT_STRIDE)));
        end
      end
    end
  end

  // Every slot is either queued somewhere or held by exactly one stage.
  always_comb begin
    slot_total_c = 0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      slot_total_c = slot_total_c + 32'(q_count[k]) + 32'(stage_busy[k]);
    end
  end

  push_full_a: assert property (@(posedge clk) disable iff (rst) (q_push & q_full) == '0);
  conserve_a:  assert property (@(posedge clk) disable iff (rst) slot_total_c == NUM_SLOTS);

endmodule

// File: tb/tb_frame_slot_manager.sv
// Directed bench for frame_slot_manager: ring order, full loop, stall/drop,
// protocol error and mid-frame reset.
module tb_frame_slot_manager;

  localparam int unsigned AW  = 32;
  localparam int unsigned NST = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NST-1:0]  stage_req;
  logic [NST-1:0]  stage_done;
  logic [NST-1:0]  stage_grant;
  logic [NST*AW-1:0] stage_base_addr;
  logic [NST-1:0]  stage_busy;
  logic [2:0]      free_slots;
  logic [15:0]     drop_count;
  logic            protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  frame_slot_manager u_dut (
    .clk             (clk),
    .rst             (rst),
    .stage_req       (stage_req),
    .stage_done      (stage_done),
    .stage_grant     (stage_grant),
    .stage_base_addr (stage_base_addr),
    .stage_busy      (stage_busy),
    .free_slots      (free_slots),
    .drop_count      (drop_count),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] base_of(input int k);
    return stage_base_addr[k*AW +: AW];
  endfunction

  // One grant then one done for stage k; free_slots checked after each edge.
  task automatic serve(input int k, input logic [31:0] exp_base,
                       input int exp_free_g, input int exp_free_d, input bit release_req);
    stage_req[k] = 1'b1;
    tick();
    check($sformatf("grant%0d", k), 64'(stage_grant[k]), 64'd1);
    check($sformatf("base%0d", k),  64'(base_of(k)),     64'(exp_base));
    check($sformatf("busy%0d", k),  64'(stage_busy[k]),  64'd1);
    check($sformatf("free_g%0d", k), 64'(free_slots),    64'(exp_free_g));
    stage_done[k] = 1'b1;
    if (release_req) stage_req[k] = 1'b0;
    tick();
    check($sformatf("grant_off%0d", k), 64'(stage_grant[k]), 64'd0);
    check($sformatf("idle%0d", k),      64'(stage_busy[k]),  64'd0);
    check($sformatf("free_d%0d", k),    64'(free_slots),     64'(exp_free_d));
    stage_done[k] = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_grant"}, 64'(stage_grant), 64'd0);
    check({tag, "_busy"},  64'(stage_busy),  64'd0);
    for (int k = 0; k < int'(NST); k++) check({tag, "_base"}, 64'(base_of(k)), 64'd0);
    check({tag, "_free"},  64'(free_slots),   64'd4);
    check({tag, "_drop"},  64'(drop_count),   64'd0);
    check({tag, "_err"},   64'(protocol_err), 64'd0);
  endtask

  initial begin
    int          seen;
    logic [31:0] seen_base;

    rst        = 1'b1;
    stage_req  = '0;
    stage_done = '0;
    tick();
    tick();
    check_reset_state("rst0");
    rst = 1'b0;

    // Writer fills all four slots in order.
    for (int i = 0; i < 4; i++) serve(0, 32'(i) * 32'h0010_0000, 3 - i, 3 - i, i == 3);

    // Done on an idle stage: sticky error, nothing moves.
    stage_done[1] = 1'b1;
    tick();
    stage_done[1] = 1'b0;
    check("perr_set",  64'(protocol_err), 64'd1);
    check("perr_free", 64'(free_slots),   64'd0);
    check("perr_busy", 64'(stage_busy),   64'd0);

    // Noise estimator sees slots 0,1,2,3 in writer order.
    for (int i = 0; i < 4; i++) serve(1, 32'(i) * 32'h0010_0000, 0, 0, i == 3);
    check("perr_sticky", 64'(protocol_err), 64'd1);

    // Wiener reader returns slots 0 and 1 to the free list.
    serve(2, 32'h0000_0000, 0, 1, 1'b0);
    serve(2, 32'h0010_0000, 1, 2, 1'b1);

    // Fifth writer grant reuses slot 0.
    serve(0, 32'h0000_0000, 1, 1, 1'b1);

    // All three stages grab a slot together: s0<-1, s1<-0, s2<-2.
    stage_req = 3'b111;
    tick();
    check("all_grant", 64'(stage_grant), 64'h7);
    check("all_busy",  64'(stage_busy),  64'h7);
    check("all_base0", 64'(base_of(0)),  64'h0010_0000);
    check("all_base1", 64'(base_of(1)),  64'h0000_0000);
    check("all_base2", 64'(base_of(2)),  64'h0020_0000);
    check("all_free",  64'(free_slots),  64'd0);

    // Mid-frame reset with requests still asserted.
    rst = 1'b1;
    tick();
    check_reset_state("rst1");
    rst       = 1'b0;
    stage_req = '0;

    // Writer runs ahead of stalled readers.
    for (int i = 0; i < 4; i++) serve(0, 32'(i) * 32'h0010_0000, 3 - i, 3 - i, 1'b0);
    seen      = 0;
    seen_base = '1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (stage_grant[0]) begin
        seen++;
        seen_base = base_of(0);
      end
    end
`ifdef FRAME_SLOT_DROP_EN
    check("drop_grants", 64'(seen),          64'd1);
    check("drop_base",   64'(seen_base),     64'd0);
    check("drop_count",  64'(drop_count),    64'd1);
    check("drop_busy",   64'(stage_busy[0]), 64'd1);
`else
    check("stall_grants", 64'(seen),          64'd0);
    check("stall_drop",   64'(drop_count),    64'd0);
    check("stall_busy",   64'(stage_busy[0]), 64'd0);
`endif
    check("stall_free", 64'(free_slots), 64'd0);
    stage_req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
